// File: rtl/uart_rx_if.sv
// Serial-line and system-side signal bundle for the UART receiver.
// The master drives the line and frame configuration; the slave is the receiver.
interface uart_rx_if #(
    parameter int PRESCALE_W = 6
);
    logic                  RX_IN;
    logic [PRESCALE_W-1:0] Prescale;
    logic                  Par_En;
    logic                  Par_Typ;
    logic [7:0]            P_DATA;
    logic                  Data_Valid;
    logic                  Par_Err;
    logic                  Stp_Err;

    modport master (
        output RX_IN, Prescale, Par_En, Par_Typ,
        input  P_DATA, Data_Valid, Par_Err, Stp_Err
    );

    modport slave (
        input  RX_IN, Prescale, Par_En, Par_Typ,
        output P_DATA, Data_Valid, Par_Err, Stp_Err
    );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start, 8 data bits LSB first, optional parity, stop.
// Each bit is the majority of three samples around the bit centre.
module uart_rx #(
    parameter int PRESCALE_W = 6
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_rx_if.slave  bus
);
    localparam int PW = PRESCALE_W;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t          r_state;
    logic [PW-1:0]   r_edge_cnt;
    logic [2:0]      r_bit_cnt;
    logic [PW-1:0]   r_prescale;
    logic            r_par_en;
    logic            r_par_typ;
    logic [2:0]      r_smp;
    logic [7:0]      r_shift;
    logic            r_par_bad;
    logic [7:0]      r_pdata;
    logic            r_dv;
    logic            r_pe;
    logic            r_se;

    logic [PW-1:0]   w_half;
    logic            w_samp;
    logic            w_last;
    logic            w_bit;
    logic            w_par_exp;

    assign w_half    = r_prescale >> 1;
    assign w_samp    = (r_edge_cnt == w_half - PW'(1)) || (r_edge_cnt == w_half) ||
                       (r_edge_cnt == w_half + PW'(1));
    assign w_last    = (r_edge_cnt == r_prescale - PW'(1));
    assign w_bit     = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_smp[2]) | (r_smp[1] & r_smp[2]);
    assign w_par_exp = r_par_typ ? ~^r_shift : ^r_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
            r_prescale <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_smp      <= '0;
            r_shift    <= '0;
            r_par_bad  <= 1'b0;
            r_pdata    <= '0;
            r_dv       <= 1'b0;
            r_pe       <= 1'b0;
            r_se       <= 1'b0;
        end else begin
            r_dv <= 1'b0;
            r_pe <= 1'b0;
            r_se <= 1'b0;
            if (r_state == S_IDLE) begin
                if (!bus.RX_IN) begin
                    r_state    <= S_START;
                    r_edge_cnt <= '0;
                    r_bit_cnt  <= '0;
                    r_par_bad  <= 1'b0;
                    r_prescale <= bus.Prescale;
                    r_par_en   <= bus.Par_En;
                    r_par_typ  <= bus.Par_Typ;
                end
            end else begin
                if (w_samp)
                    r_smp <= {r_smp[1:0], bus.RX_IN};
                if (w_last) begin
                    r_edge_cnt <= '0;
                    case (r_state)
                        // A high start bit at its centre is a line glitch.
                        S_START: r_state <= w_bit ? S_IDLE : S_DATA;
                        S_DATA: begin
                            r_shift[r_bit_cnt] <= w_bit;
                            r_bit_cnt          <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7)
                                r_state <= r_par_en ? S_PARITY : S_STOP;
                        end
                        S_PARITY: begin
                            r_par_bad <= (w_bit != w_par_exp);
                            r_state   <= S_STOP;
                        end
                        S_STOP: begin
                            r_se <= ~w_bit;
                            r_pe <= r_par_en & r_par_bad;
                            if (w_bit && !(r_par_en && r_par_bad)) begin
                                r_dv    <= 1'b1;
                                r_pdata <= r_shift;
                            end
                            r_state <= S_IDLE;
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end else begin
                    r_edge_cnt <= r_edge_cnt + PW'(1);
                end
            end
        end
    end

    assign bus.P_DATA     = r_pdata;
    assign bus.Data_Valid = r_dv;
    assign bus.Par_Err    = r_pe;
    assign bus.Stp_Err    = r_se;
endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx: a frame-level model predicts when each
// status pulse appears and what it carries; a monitor pops and compares.
module tb_uart_rx;
    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    longint cyc = 0;
    int    errors = 0;
    int    checks = 0;

    uart_rx_if #(.PRESCALE_W(6)) bus ();
    uart_rx #(.PRESCALE_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint     t;
        bit         dv;
        bit         pe;
        bit         se;
        logic [7:0] pd;
    } exp_t;

    exp_t       q[$];
    exp_t       me;
    logic [7:0] model_pd = 8'h00;
    longint     busy_end = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every status pulse must match the oldest predicted frame result.
    always @(negedge clk) begin
        if (rst_n && (bus.Data_Valid || bus.Par_Err || bus.Stp_Err)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse dv=%0b pe=%0b se=%0b at cycle %0d",
                         bus.Data_Valid, bus.Par_Err, bus.Stp_Err, cyc);
            end else begin
                me = q.pop_front();
                chk("pulse_time", cyc, me.t);
                chk("data_valid", bus.Data_Valid, me.dv);
                chk("par_err", bus.Par_Err, me.pe);
                chk("stp_err", bus.Stp_Err, me.se);
                chk("p_data", bus.P_DATA, me.pd);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.RX_IN = 1'b1;
        repeat (n) tick();
    endtask

    // Drive one frame tick by tick. The receiver is free again one tick after its
    // STOP exit, so a start bit seen earlier is only picked up at busy_end+1.
    task automatic send(input int p, input bit pen, input bit ptyp, input logic [7:0] d,
                        input bit bad_par, input bit stop, input int flip_bit,
                        input int abort_bit, input bit scramble);
        bit     bits[11];
        int     n;
        bit     par;
        longint c0;
        longint dd;
        bit     pe, se, dv;
        while (busy_end - cyc >= 2) tick();
        bus.Prescale = 6'(p);
        bus.Par_En   = pen;
        bus.Par_Typ  = ptyp;
        c0 = (cyc + 1 > busy_end + 1) ? cyc + 1 : busy_end + 1;
        dd = c0 - cyc;
        par = (ptyp ? ~^d : ^d) ^ bad_par;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        n = pen ? 11 : 10;
        if (pen) bits[9] = par;
        bits[n-1] = stop;
        pe = pen & bad_par;
        se = !stop;
        dv = !pe && !se;
        if (abort_bit < 0) begin
            if (dv) model_pd = d;
            q.push_back('{c0 + longint'(n * p), dv, pe, se, model_pd});
            busy_end = c0 + longint'(n * p);
        end
        for (int k = 0; k < n; k++) begin
            for (int t = 0; t < p; t++) begin
                if (abort_bit == k && t == p / 2) begin
                    rst_n = 1'b0;
                    #1;
                    chk("rst_p_data", bus.P_DATA, 0);
                    chk("rst_dv", bus.Data_Valid, 0);
                    chk("rst_pe", bus.Par_Err, 0);
                    chk("rst_se", bus.Stp_Err, 0);
                    model_pd = 8'h00;
                    idle(3);
                    rst_n = 1'b1;
                    busy_end = cyc;
                    return;
                end
                if (scramble && k == n / 2 && t == 0) begin
                    bus.Prescale = 6'(8 << $urandom_range(0, 2));
                    bus.Par_En   = 1'($urandom);
                    bus.Par_Typ  = 1'($urandom);
                end
                bus.RX_IN = bits[k] ^ ((k == flip_bit) && (longint'(t) == dd + p / 2));
                tick();
            end
        end
        bus.RX_IN = 1'b1;
    endtask

    task automatic glitch(input int p, input int len);
        longint c0;
        bus.Prescale = 6'(p);
        c0 = (cyc + 1 > busy_end + 1) ? cyc + 1 : busy_end + 1;
        busy_end = c0 + p;
        bus.RX_IN = 1'b0;
        repeat (len) tick();
        bus.RX_IN = 1'b1;
    endtask

    initial begin
        int p;
        bit b2b;
        bus.RX_IN = 1'b1;
        bus.Prescale = 6'd8;
        bus.Par_En = 1'b0;
        bus.Par_Typ = 1'b0;
        repeat (3) tick();
        chk("reset_p_data", bus.P_DATA, 0);
        chk("reset_dv", bus.Data_Valid, 0);
        chk("reset_pe", bus.Par_Err, 0);
        chk("reset_se", bus.Stp_Err, 0);
        rst_n = 1'b1;
        idle(5);

        send(8, 0, 0, 8'hA5, 0, 1, -1, -1, 0);
        idle(10);
        send(16, 1, 0, 8'h3C, 0, 1, -1, -1, 0);
        idle(10);
        send(16, 1, 1, 8'h3C, 1, 1, -1, -1, 0);   // odd parity, line carries 0
        idle(10);
        send(8, 0, 0, 8'h55, 0, 0, -1, -1, 0);
        idle(10);
        glitch(8, 3);
        idle(20);
        send(8, 0, 0, 8'h96, 0, 1, 3, -1, 0);
        idle(10);
        send(32, 0, 0, 8'h00, 0, 1, -1, -1, 0);
        send(32, 0, 0, 8'hFF, 0, 1, -1, -1, 0);
        idle(10);
        send(8, 0, 0, 8'h81, 0, 1, -1, 5, 0);
        idle(4);
        send(8, 0, 0, 8'h81, 0, 1, -1, -1, 0);
        idle(10);

        for (int i = 0; i < 40; i++) begin
            p = 8 << $urandom_range(0, 2);
            b2b = ($urandom_range(0, 2) == 0);
            if (!b2b) idle($urandom_range(1, 12));
            send(p, 1'($urandom), 1'($urandom), 8'($urandom),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) != 0,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : -1, -1, 1);
        end

        for (int i = 0; i < 4000 && q.size() > 0; i++) tick();
        chk("queue_drain", q.size(), 0);
        idle(5);
        chk("final_p_data", bus.P_DATA, model_pd);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
